adc_pair_sequencer: RTL and testbench
=====================================

// Module: adc_pair_sequencer
// PURPOSE
//  Sequences the two AD7643 ADCs (ch0/ch1): common conversion start, BUSY wait, serial
//  slave-mode readout on a shared SCLK, then writes ch0 and ch1 samples into the shared
//  sample memory (dmem) at consecutive addresses. Sits between the USB command decoder
//  (START/STOP, frame period) and dmem; it is the only dmem writer while RUNNING=1.
// PARAMETERS
//  NBITS        18   ADC word width, shifted MSB first
//  ADDR_W       14   dmem address width; buffer depth 2**ADDR_W words
//  SCLK_HALF    3    CLK cycles per SCLK half-period (>=1)
//  CNV_LOW      4    CLK cycles CNVST is held low
//  BUSY_TO      255  max CLK cycles in BUSY wait before timeout
// PORTS
//  CLK        in   1       system clock, all logic on posedge
//  RST        in   1       synchronous, active-high reset
//  START      in   1       1-cycle pulse: clear ADDR/flags, begin acquisition
//  STOP       in   1       1-cycle pulse: finish current frame, then idle
//  WRAP_EN    in   1       1: address wraps at depth; 0: stop with FULL
//  PERIOD     in   16      frame period in CLK cycles (CONV start to next CONV start)
//  ADCS       out  1       ADC chip select, active low (both ADCs)
//  ADCNVST    out  1       conversion start, active low (both ADCs)
//  ADSCLK     out  1       shared serial clock
//  ADBUSY0/1  in   1       ADC busy, active high
//  ADSDOUT0/1 in   1       ADC serial data
//  MEM_WE     out  1       dmem write strobe, 1 cycle
//  MEM_ADDR   out  ADDR_W  dmem address
//  MEM_DATA   out  16      dmem data = sample[NBITS-1:NBITS-16]
//  RUNNING    out  1       acquisition active
//  FULL       out  1       sticky: buffer filled with WRAP_EN=0
//  TOERR      out  1       sticky: BUSY timeout occurred
// BEHAVIOUR
//  Reset: state IDLE; ADCS=1, ADCNVST=1, ADSCLK=0, MEM_WE=0, MEM_ADDR=0, MEM_DATA=0,
//   RUNNING=0, FULL=0, TOERR=0; all counters 0. RST mid-frame aborts with no further write.
//  States: IDLE -> CONV -> BUSYW -> SHIFT -> WR0 -> WR1 -> HOLD -> CONV|IDLE.
//  IDLE: START -> clear MEM_ADDR, FULL, TOERR; frame counter=0; RUNNING=1; go CONV.
//   START while RUNNING is ignored.
//  Frame counter counts every cycle from CONV entry; expiry at count==max(PERIOD,min)-1,
//   min = frame length; PERIOD below min runs back-to-back frames.
//  CONV: ADCS=0, ADCNVST=0 for CNV_LOW cycles, then ADCNVST=1, go BUSYW.
//  BUSYW: wait BUSY0 and BUSY1 both low after at least one seen high (sync 2-FF each).
//   Timeout after BUSY_TO cycles -> TOERR=1, skip WR0/WR1, go HOLD.
//  SHIFT: NBITS SCLK periods; SCLK rises after SCLK_HALF cycles low; ADSDOUTx sampled into
//   shift regs on the CLK where ADSCLK falls (data valid on falling edge). Ends ADSCLK=0.
//  WR0: MEM_WE=1, MEM_DATA=ch0, MEM_ADDR=A. WR1: MEM_WE=1, MEM_DATA=ch1, MEM_ADDR=A+1.
//   ADDR advances by 2 per frame; ADCS=1 after WR1.
//  Wrap: at address 2**ADDR_W-1 written, next is 0 if WRAP_EN=1; else FULL=1, RUNNING=0,
//   go IDLE. Depth is even, so a pair never splits across the wrap.
//  HOLD: wait frame-counter expiry, then CONV; if STOP was latched (any time while
//   RUNNING), go IDLE, RUNNING=0. STOP and START in the same cycle: STOP wins.
//  MEM_WE only in WR0/WR1; never two writes to the same address within a frame.
// TESTING
//  1 RST, START, PERIOD=200, BUSY pulse 20 cycles, SDOUT0=0x2AAAA, SDOUT1=0x15555 ->
//    writes (0,0xAAAA),(1,0x5555); 2nd frame CONV 200 cycles after the 1st.
//  2 ADDR_W=3, WRAP_EN=0, 4 frames -> addrs 0..7 written, FULL=1, RUNNING=0, no 5th CONV.
//  3 ADDR_W=3, WRAP_EN=1, 5 frames -> 5th frame writes addrs 0,1; FULL stays 0.
//  4 BUSY1 stuck high -> TOERR=1 after 255 cycles, no MEM_WE that frame, next frame runs.
//  5 STOP mid-SHIFT -> current pair written, then IDLE, RUNNING=0; START restarts at addr 0.
//  6 RST asserted in SHIFT -> next cycle all outputs at reset values, no MEM_WE.

Source files
------------

// File: rtl/adc_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_pair_sequencer
// Brief    : Runs paired AD7643 conversions, reads both words serially and
//            writes the ch0/ch1 pair into sample memory at consecutive addresses.
// Revision : 1.0 - initial release
// ============================================================================
module adc_pair_sequencer #(
    parameter int NBITS     = 18,
    parameter int ADDR_W    = 14,
    parameter int SCLK_HALF = 3,
    parameter int CNV_LOW   = 4,
    parameter int BUSY_TO   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              wrap_en,
    input  logic [15:0]       period,
    output logic              adcs,
    output logic              adcnvst,
    output logic              adsclk,
    input  logic              adbusy0,
    input  logic              adbusy1,
    input  logic              adsdout0,
    input  logic              adsdout1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              running,
    output logic              full,
    output logic              toerr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_BUSYW = 3'd2,
        S_SHIFT = 3'd3,
        S_WR0   = 3'd4,
        S_WR1   = 3'd5,
        S_HOLD  = 3'd6
    } state_t;

    localparam logic [15:0]       CNV_LAST  = 16'(CNV_LOW - 1);
    localparam logic [15:0]       BUSY_LAST = 16'(BUSY_TO - 1);
    localparam logic [7:0]        HALF_LAST = 8'(SCLK_HALF - 1);
    localparam logic [7:0]        BIT_LAST  = 8'(NBITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TWO  = ADDR_W'(2);

    state_t            state;
    logic              busy0_meta;
    logic              busy0_sync;
    logic              busy1_meta;
    logic              busy1_sync;
    logic              busy_seen;
    logic [15:0]       tcnt;
    logic [7:0]        hcnt;
    logic [7:0]        bcnt;
    logic [15:0]       frame_cnt;
    logic              stop_lat;
    logic [ADDR_W-1:0] base_addr;
    logic [NBITS-1:0]  sr0;
    logic [NBITS-1:0]  sr1;

    logic [NBITS-1:0]  sh0_next;
    logic [NBITS-1:0]  sh1_next;
    logic [15:0]       period_last;
    logic              frame_done;
    logic              busy_any;
    logic              stop_req;

    // A frame longer than PERIOD simply expires on arrival in HOLD,
    // which yields back-to-back frames.
    always_comb begin
        sh0_next    = {sr0[NBITS-2:0], adsdout0};
        sh1_next    = {sr1[NBITS-2:0], adsdout1};
        period_last = (period == 16'd0) ? 16'd0 : (period - 16'd1);
        frame_done  = (frame_cnt >= period_last);
        busy_any    = busy0_sync | busy1_sync;
        stop_req    = stop_lat | stop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy0_meta <= 1'b0;
            busy0_sync <= 1'b0;
            busy1_meta <= 1'b0;
            busy1_sync <= 1'b0;
            busy_seen  <= 1'b0;
            tcnt       <= 16'd0;
            hcnt       <= 8'd0;
            bcnt       <= 8'd0;
            frame_cnt  <= 16'd0;
            stop_lat   <= 1'b0;
            base_addr  <= '0;
            sr0        <= '0;
            sr1        <= '0;
            adcs       <= 1'b1;
            adcnvst    <= 1'b1;
            adsclk     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= 16'd0;
            running    <= 1'b0;
            full       <= 1'b0;
            toerr      <= 1'b0;
        end else begin
            busy0_meta <= adbusy0;
            busy0_sync <= busy0_meta;
            busy1_meta <= adbusy1;
            busy1_sync <= busy1_meta;
            mem_we     <= 1'b0;

            if (frame_cnt != 16'hFFFF) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (running && stop) begin
                stop_lat <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    stop_lat <= 1'b0;
                    if (start && !stop) begin
                        base_addr <= '0;
                        mem_addr  <= '0;
                        full      <= 1'b0;
                        toerr     <= 1'b0;
                        running   <= 1'b1;
                        state     <= S_CONV;
                        frame_cnt <= 16'd0;
                        tcnt      <= 16'd0;
                        busy_seen <= 1'b0;
                        adcs      <= 1'b0;
                        adcnvst   <= 1'b0;
                    end
                end

                S_CONV: begin
                    if (busy_any) begin
                        busy_seen <= 1'b1;
                    end
                    if (tcnt == CNV_LAST) begin
                        adcnvst <= 1'b1;
                        tcnt    <= 16'd0;
                        state   <= S_BUSYW;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end

                S_BUSYW: begin
                    if (busy_any) begin
                        busy_seen <= 1'b1;
                    end
                    if (busy_seen && !busy_any) begin
                        hcnt   <= 8'd0;
                        bcnt   <= 8'd0;
                        adsclk <= 1'b0;
                        state  <= S_SHIFT;
                    end else if (tcnt == BUSY_LAST) begin
                        toerr <= 1'b1;
                        adcs  <= 1'b1;
                        state <= S_HOLD;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end

                S_SHIFT: begin
                    if (hcnt == HALF_LAST) begin
                        hcnt <= 8'd0;
                        if (!adsclk) begin
                            adsclk <= 1'b1;
                        end else begin
                            // Falling SCLK edge: data bit is valid, capture it.
                            adsclk <= 1'b0;
                            sr0    <= sh0_next;
                            sr1    <= sh1_next;
                            if (bcnt == BIT_LAST) begin
                                mem_we   <= 1'b1;
                                mem_addr <= base_addr;
                                mem_data <= sh0_next[NBITS-1 -: 16];
                                state    <= S_WR0;
                            end else begin
                                bcnt <= bcnt + 8'd1;
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end

                S_WR0: begin
                    mem_we   <= 1'b1;
                    mem_addr <= base_addr + ADDR_ONE;
                    mem_data <= sr1[NBITS-1 -: 16];
                    state    <= S_WR1;
                end

                S_WR1: begin
                    adcs <= 1'b1;
                    // mem_addr already holds the ch1 address just written.
                    if (mem_addr == ADDR_LAST) begin
                        if (wrap_en) begin
                            base_addr <= '0;
                            state     <= S_HOLD;
                        end else begin
                            full    <= 1'b1;
                            running <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end else begin
                        base_addr <= base_addr + ADDR_TWO;
                        state     <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (stop_req) begin
                        running <= 1'b0;
                        state   <= S_IDLE;
                    end else if (frame_done) begin
                        state     <= S_CONV;
                        frame_cnt <= 16'd0;
                        tcnt      <= 16'd0;
                        busy_seen <= 1'b0;
                        adcs      <= 1'b0;
                        adcnvst   <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_pair_sequencer.sv
`default_nettype none
// Bench for adc_pair_sequencer: behavioural AD7643 pair plus a write scoreboard,
// one task per scenario.
module tb_adc_pair_sequencer;

    localparam int NBITS   = 18;
    localparam int ADDR_W  = 3;
    localparam int CNV_LOW = 4;
    localparam int BUSY_TO = 255;

    localparam int SIG_RUN = 0;
    localparam int SIG_CNV = 1;
    localparam int SIG_SCK = 2;
    localparam int SIG_TOE = 3;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              start   = 1'b0;
    logic              stop    = 1'b0;
    logic              wrap_en = 1'b0;
    logic [15:0]       period  = 16'd200;
    logic              adbusy0 = 1'b0;
    logic              adbusy1 = 1'b0;
    logic              adsdout0 = 1'b0;
    logic              adsdout1 = 1'b0;
    logic              adcs;
    logic              adcnvst;
    logic              adsclk;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              running;
    logic              full;
    logic              toerr;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t              exp_q[$];
    wr_t              mon_e;
    int               tests_run  = 0;
    int               fails      = 0;
    int               cyc        = 0;
    int               conv_count = 0;
    int               busy_len   = 20;
    int               bit_idx    = 0;
    bit               stuck1     = 1'b0;
    logic [NBITS-1:0] word0      = '0;
    logic [NBITS-1:0] word1      = '0;

    adc_pair_sequencer #(
        .NBITS     (NBITS),
        .ADDR_W    (ADDR_W),
        .SCLK_HALF (3),
        .CNV_LOW   (CNV_LOW),
        .BUSY_TO   (BUSY_TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .wrap_en  (wrap_en),
        .period   (period),
        .adcs     (adcs),
        .adcnvst  (adcnvst),
        .adsclk   (adsclk),
        .adbusy0  (adbusy0),
        .adbusy1  (adbusy1),
        .adsdout0 (adsdout0),
        .adsdout1 (adsdout1),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .running  (running),
        .full     (full),
        .toerr    (toerr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, wanted completion", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- ADC pair model and scoreboard monitor ----------------
    task automatic adc_busy_model();
        forever begin
            @(negedge adcnvst);
            @(negedge clk);
            adbusy0 = 1'b1;
            adbusy1 = 1'b1;
            repeat (busy_len) @(negedge clk);
            adbusy0 = 1'b0;
            if (!stuck1) adbusy1 = 1'b0;
            bit_idx  = 0;
            adsdout0 = word0[NBITS-1];
            adsdout1 = word1[NBITS-1];
        end
    endtask

    task automatic adc_data_model();
        forever begin
            @(negedge adsclk);
            #1;
            if (bit_idx < NBITS - 1) begin
                bit_idx  = bit_idx + 1;
                adsdout0 = word0[NBITS-1-bit_idx];
                adsdout1 = word1[NBITS-1-bit_idx];
            end
        end
    endtask

    task automatic conv_counter();
        forever begin
            @(negedge adcnvst);
            conv_count = conv_count + 1;
        end
    endtask

    task automatic scoreboard_monitor();
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                tests_run = tests_run + 1;
                if (exp_q.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL write_unexpected: got addr %0d data %h, wanted no write",
                             mem_addr, mem_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({mem_addr, mem_data} !== {mon_e.addr, mon_e.data}) begin
                        fails = fails + 1;
                        $display("FAIL write_pair: got addr %0d data %h, wanted addr %0d data %h",
                                 mem_addr, mem_data, mon_e.addr, mon_e.data);
                    end
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic sig(input int sel);
        case (sel)
            SIG_RUN: return running;
            SIG_CNV: return adcnvst;
            SIG_SCK: return adsclk;
            SIG_TOE: return toerr;
            default: return 1'bx;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input int max, input string name);
        int n;
        n = 0;
        while (sig(sel) !== val && n < max) begin
            @(negedge clk);
            n = n + 1;
        end
        if (sig(sel) !== val) begin
            tests_run = tests_run + 1;
            fails     = fails + 1;
            $display("FAIL %s: got %b after %0d cycles, wanted %b", name, sig(sel), max, val);
        end
    endtask

    task automatic push_pair(input logic [ADDR_W-1:0] a);
        wr_t e;
        e.addr = a;
        e.data = word0[NBITS-1 -: 16];
        exp_q.push_back(e);
        e.addr = a + 1'b1;
        e.data = word1[NBITS-1 -: 16];
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run = tests_run + 1;
        if ({adcs, adcnvst, adsclk, mem_we, running, full, toerr} !== 7'b1100000) begin
            fails = fails + 1;
            $display("FAIL reset_ctrl: got %b, wanted 1100000",
                     {adcs, adcnvst, adsclk, mem_we, running, full, toerr});
        end
        tests_run = tests_run + 1;
        if ({mem_addr, mem_data} !== 19'd0) begin
            fails = fails + 1;
            $display("FAIL reset_bus: got addr %0d data %h, wanted 0/0000", mem_addr, mem_data);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        tests_run = tests_run + 1;
        if (running !== 1'b0 || adcnvst !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL idle_hold: got running %b cnvst %b, wanted 0/1", running, adcnvst);
        end
    endtask

    task automatic test_basic();
        int t1, t2, n, c0;
        word0 = 18'h2AAAA; word1 = 18'h15555;
        busy_len = 20; stuck1 = 1'b0; period = 16'd200; wrap_en = 1'b1;
        c0 = conv_count;
        push_pair(3'd0);
        push_pair(3'd2);
        pulse_start();
        tests_run = tests_run + 1;
        if ({running, adcnvst, adcs} !== 3'b100) begin
            fails = fails + 1;
            $display("FAIL start_conv: got run/cnv/cs %b, wanted 100", {running, adcnvst, adcs});
        end
        t1 = cyc;
        n  = 0;
        while (adcnvst === 1'b0 && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        tests_run = tests_run + 1;
        if (n != CNV_LOW) begin
            fails = fails + 1;
            $display("FAIL cnvst_width: got %0d cycles, wanted %0d", n, CNV_LOW);
        end
        wait_for(SIG_CNV, 1'b0, 400, "second_conv");
        t2 = cyc;
        tests_run = tests_run + 1;
        if (t2 - t1 != 200) begin
            fails = fails + 1;
            $display("FAIL frame_period: got %0d cycles, wanted 200", t2 - t1);
        end
        pulse_stop();
        wait_for(SIG_RUN, 1'b0, 400, "stop_idle");
        repeat (50) @(negedge clk);
        tests_run = tests_run + 1;
        if (conv_count - c0 != 2 || exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL basic_frames: got %0d convs %0d pending, wanted 2 convs 0 pending",
                     conv_count - c0, exp_q.size());
        end
    endtask

    task automatic test_full();
        int c0;
        word0 = 18'h12345; word1 = 18'h2FEDC;
        period = 16'd0; wrap_en = 1'b0;
        c0 = conv_count;
        push_pair(3'd0); push_pair(3'd2); push_pair(3'd4); push_pair(3'd6);
        pulse_start();
        wait_for(SIG_RUN, 1'b0, 2000, "full_stop");
        tests_run = tests_run + 1;
        if (full !== 1'b1) begin
            fails = fails + 1;
            $display("FAIL full_flag: got %b, wanted 1", full);
        end
        repeat (300) @(negedge clk);
        tests_run = tests_run + 1;
        if (conv_count - c0 != 4 || exp_q.size() != 0 || running !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL full_frames: got %0d convs %0d pending run %b, wanted 4/0/0",
                     conv_count - c0, exp_q.size(), running);
        end
    endtask

    task automatic test_wrap();
        int c0, n;
        word0 = 18'h3FFFF; word1 = 18'h00000;
        period = 16'd0; wrap_en = 1'b1;
        c0 = conv_count;
        push_pair(3'd0); push_pair(3'd2); push_pair(3'd4); push_pair(3'd6); push_pair(3'd0);
        pulse_start();
        tests_run = tests_run + 1;
        if (full !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL full_cleared: got %b, wanted 0", full);
        end
        n = 0;
        while (conv_count - c0 < 5 && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        pulse_stop();
        wait_for(SIG_RUN, 1'b0, 600, "wrap_stop");
        repeat (100) @(negedge clk);
        tests_run = tests_run + 1;
        if (conv_count - c0 != 5 || exp_q.size() != 0 || full !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL wrap_frames: got %0d convs %0d pending full %b, wanted 5/0/0",
                     conv_count - c0, exp_q.size(), full);
        end
    endtask

    task automatic test_timeout();
        int t1, t2, c0;
        word0 = 18'h0F0F0; word1 = 18'h30303;
        period = 16'd200; wrap_en = 1'b1; stuck1 = 1'b1;
        c0 = conv_count;
        pulse_start();
        t1 = cyc;
        wait_for(SIG_TOE, 1'b1, 400, "toerr_rise");
        t2 = cyc;
        tests_run = tests_run + 1;
        if (t2 - t1 != CNV_LOW + BUSY_TO) begin
            fails = fails + 1;
            $display("FAIL toerr_delay: got %0d cycles, wanted %0d", t2 - t1, CNV_LOW + BUSY_TO);
        end
        stuck1  = 1'b0;
        adbusy1 = 1'b0;
        push_pair(3'd0);
        wait_for(SIG_CNV, 1'b0, 10, "conv_after_timeout");
        pulse_stop();
        wait_for(SIG_RUN, 1'b0, 600, "timeout_stop");
        repeat (20) @(negedge clk);
        tests_run = tests_run + 1;
        if (toerr !== 1'b1 || exp_q.size() != 0 || conv_count - c0 != 2) begin
            fails = fails + 1;
            $display("FAIL timeout_recover: got toerr %b %0d pending %0d convs, wanted 1/0/2",
                     toerr, exp_q.size(), conv_count - c0);
        end
    endtask

    task automatic test_stop_shift();
        int c0;
        c0 = conv_count;
        @(negedge clk) begin start = 1'b1; stop = 1'b1; end
        @(negedge clk) begin start = 1'b0; stop = 1'b0; end
        repeat (2) @(negedge clk);
        tests_run = tests_run + 1;
        if (running !== 1'b0 || conv_count != c0) begin
            fails = fails + 1;
            $display("FAIL start_stop_same: got run %b convs %0d, wanted 0/0",
                     running, conv_count - c0);
        end
        word0 = 18'h1C71C; word1 = 18'h0E38E; period = 16'd200;
        push_pair(3'd0);
        pulse_start();
        tests_run = tests_run + 1;
        if (toerr !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL toerr_cleared: got %b, wanted 0", toerr);
        end
        wait_for(SIG_SCK, 1'b1, 100, "shift_started");
        pulse_stop();
        wait_for(SIG_RUN, 1'b0, 400, "stop_after_pair");
        repeat (20) @(negedge clk);
        tests_run = tests_run + 1;
        if (conv_count - c0 != 1 || exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL stop_mid_shift: got %0d convs %0d pending, wanted 1/0",
                     conv_count - c0, exp_q.size());
        end
        word0 = 18'h25A5A; word1 = 18'h0C3C3;
        push_pair(3'd0);
        pulse_start();
        wait_for(SIG_SCK, 1'b1, 100, "restart_shift");
        pulse_stop();
        wait_for(SIG_RUN, 1'b0, 400, "restart_stop");
        repeat (20) @(negedge clk);
        tests_run = tests_run + 1;
        if (conv_count - c0 != 2 || exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL restart_addr0: got %0d convs %0d pending, wanted 2/0",
                     conv_count - c0, exp_q.size());
        end
    endtask

    task automatic test_reset_shift();
        int c0;
        c0 = conv_count;
        word0 = 18'h3C3C3; word1 = 18'h1E1E1;
        pulse_start();
        wait_for(SIG_SCK, 1'b1, 100, "shift_before_reset");
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        tests_run = tests_run + 1;
        if ({adcs, adcnvst, adsclk, mem_we, running, full, toerr, mem_addr, mem_data}
                !== {7'b1100000, 19'd0}) begin
            fails = fails + 1;
            $display("FAIL reset_mid_shift: got ctrl %b addr %0d data %h, wanted 1100000/0/0000",
                     {adcs, adcnvst, adsclk, mem_we, running, full, toerr}, mem_addr, mem_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        tests_run = tests_run + 1;
        if (running !== 1'b0 || conv_count - c0 != 1 || exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL after_reset_idle: got run %b %0d convs %0d pending, wanted 0/1/0",
                     running, conv_count - c0, exp_q.size());
        end
    endtask

    initial begin
        fork
            adc_busy_model();
            adc_data_model();
            conv_counter();
            scoreboard_monitor();
        join_none
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_timeout();
        test_stop_shift();
        test_reset_shift();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
